// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with tree pseudo-LRU.
// Lookup is combinational on read_pc. Resolved branches are written back
// through the update port. btb_entry layout is {target_address[31:0], br_jal_jalr[1:0]}
// with br=2'b00, jal=2'b01, jalr=2'b10; 2'b11 is illegal and ignored.
// Optional feature macro: BTB_PERF_EN adds read_req and three saturating
// performance counters (perf_lookups, perf_hits, perf_evictions).
module btb_assoc #(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] read_pc,
    output logic        read_hit,
    output logic [33:0] read_entry,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic [1:0]  update_type
`ifdef BTB_PERF_EN
    ,
    input  logic        read_req,
    output logic [31:0] perf_lookups,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_evictions
`endif
);

    localparam int TAG_W = 32 - S_INDEX - 2;
    localparam int SETS  = 1 << S_INDEX;
    localparam int LW    = $clog2(WAYS);

    // Handshake: update_valid is a single-cycle request with no ready; the
    // BTB always accepts it at the next rising edge unless rst or clear is
    // high or update_type is the illegal encoding 2'b11, in which case the
    // request is dropped with no state change.

    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [33:0]      data_q  [SETS][WAYS];
    logic [WAYS-2:0]  plru_q  [SETS];

    logic [S_INDEX-1:0] rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    logic               rd_hit;
    logic [LW-1:0]      rd_way;
    logic [33:0]        rd_entry;
    logic [WAYS-2:0]    rd_plru_next;

    logic [S_INDEX-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_legal;
    logic               up_match;
    logic [LW-1:0]      up_match_way;
    logic               up_inv;
    logic [LW-1:0]      up_inv_way;
    logic [LW-1:0]      up_way;
    logic               up_evict;
    logic [WAYS-2:0]    up_plru_base;
    logic [WAYS-2:0]    up_plru_next;

    logic               unused_pc_bits;
    assign unused_pc_bits = ^{read_pc[1:0], update_pc[1:0]};

    // Walk the tree from the root following each node's victim direction.
    function automatic logic [LW-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [LW-1:0] v;
        int            node;
        v    = '0;
        node = 0;
        for (int l = 0; l < LW; l++) begin
            v[LW-1-l] = bits[LW'(node)];
            node      = 2 * node + 1 + int'(bits[LW'(node)]);
        end
        return v;
    endfunction

    // Point every node on way w's path away from w.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [LW-1:0]   w);
        logic [WAYS-2:0] r;
        int              node;
        r    = bits;
        node = 0;
        for (int l = 0; l < LW; l++) begin
            r[LW'(node)] = ~w[LW-1-l];
            node         = 2 * node + 1 + int'(w[LW-1-l]);
        end
        return r;
    endfunction

    // Combinational lookup of the fetch PC in its indexed set.
    always_comb begin
        rd_idx   = read_pc[S_INDEX+1:2];
        rd_tag   = read_pc[31:S_INDEX+2];
        rd_hit   = 1'b0;
        rd_way   = '0;
        rd_entry = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
                rd_hit   = 1'b1;
                rd_way   = LW'(w);
                rd_entry = rd_entry | data_q[rd_idx][w];
            end
        end
        rd_plru_next = plru_touch(plru_q[rd_idx], rd_way);
        read_hit     = rd_hit & ~rst;
        read_entry   = rst ? 34'd0 : rd_entry;
    end

    // Choose the way an update writes: matching way, else lowest invalid, else PLRU victim.
    always_comb begin
        up_idx       = update_pc[S_INDEX+1:2];
        up_tag       = update_pc[31:S_INDEX+2];
        up_legal     = update_valid && (update_type != 2'b11);
        up_match     = 1'b0;
        up_match_way = '0;
        up_inv       = 1'b0;
        up_inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
                up_match     = 1'b1;
                up_match_way = LW'(w);
            end
            if (!valid_q[up_idx][w] && !up_inv) begin
                up_inv     = 1'b1;
                up_inv_way = LW'(w);
            end
        end
        if (up_match) begin
            up_way = up_match_way;
        end else if (up_inv) begin
            up_way = up_inv_way;
        end else begin
            up_way = plru_victim(plru_q[up_idx]);
        end
        up_evict = up_legal && !up_match && !up_inv;
        // A read hit in the same set is touched first so the update's touch wins.
        up_plru_base = (rd_hit && (rd_idx == up_idx)) ? rd_plru_next : plru_q[up_idx];
        up_plru_next = plru_touch(up_plru_base, up_way);
    end

    // Valid bits and PLRU state: reset/clear wipe them, otherwise apply touches and fills.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (rd_hit) begin
                plru_q[rd_idx] <= rd_plru_next;
            end
            if (up_legal) begin
                valid_q[up_idx][up_way] <= 1'b1;
                plru_q[up_idx]          <= up_plru_next;
            end
        end
    end

    // Tag and entry payload; no reset needed because valid gates their use.
    always_ff @(posedge clk) begin
        if (!rst && !clear && up_legal) begin
            tag_q[up_idx][up_way]  <= up_tag;
            data_q[up_idx][up_way] <= {update_target, update_type};
        end
    end

`ifdef BTB_PERF_EN
    localparam int PERF_COUNTER_WIDTH = 32;

    logic [PERF_COUNTER_WIDTH-1:0] perf_lookups_q;
    logic [PERF_COUNTER_WIDTH-1:0] perf_hits_q;
    logic [PERF_COUNTER_WIDTH-1:0] perf_evictions_q;

    // Saturating event counters; cleared by rst only, clear leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lookups_q   <= '0;
            perf_hits_q      <= '0;
            perf_evictions_q <= '0;
        end else begin
            if (read_req && (perf_lookups_q != '1)) begin
                perf_lookups_q <= perf_lookups_q + 1'b1;
            end
            if (read_req && rd_hit && (perf_hits_q != '1)) begin
                perf_hits_q <= perf_hits_q + 1'b1;
            end
            if (!clear && up_evict && (perf_evictions_q != '1)) begin
                perf_evictions_q <= perf_evictions_q + 1'b1;
            end
        end
    end

    assign perf_lookups   = perf_lookups_q;
    assign perf_hits      = perf_hits_q;
    assign perf_evictions = perf_evictions_q;
`endif

endmodule
